// File: rtl/param_stall_pipe.sv
// DEPTH-stage, WIDTH-bit stalling pipeline with hazard bubbles, backpressure freeze and flush.
// Optional hazard-cycle counter on stall_cnt: define PARAM_STALL_PIPE_STALL_CNT_EN.
module param_stall_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             stall_req,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic             frz;
    logic             hz;

    // An empty last stage never freezes, so stalled contents can always drain.
    assign frz       = v[DEPTH-1] & ~out_ready;
    assign hz        = stall_req & v[0];
    assign in_ready  = ~frz & ~hz & ~flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else if (flush) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else if (frz) begin
            v <= v;
        end else if (hz) begin
            // Stage 0 holds the hazarded word; a zeroed bubble enters stage 1.
            v[1] <= 1'b0;
            d[1] <= '0;
            for (int i = 2; i < DEPTH; i++) begin
                v[i] <= v[i-1];
                d[i] <= d[i-1];
            end
        end else begin
            v[0] <= in_valid;
            d[0] <= in_valid ? in_data : '0;
            for (int i = 1; i < DEPTH; i++) begin
                v[i] <= v[i-1];
                d[i] <= d[i-1];
            end
        end
    end

`ifdef PARAM_STALL_PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (hz && !frz && !flush && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_param_stall_pipe.sv
// Scoreboard bench for param_stall_pipe: directed scenarios plus randomized traffic.
module tb_param_stall_pipe;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
`ifdef PARAM_STALL_PIPE_STALL_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             stall_req;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CNT_W-1:0] stall_cnt;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] sb[$];
    logic             last_rdy;

    always #5 clk = ~clk;

    param_stall_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .stall_req(stall_req), .flush(flush),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive, record acceptance, advance past the edge.
    task automatic cyc(input logic iv, input logic [WIDTH-1:0] id, input logic sr,
                       input logic fl, input logic orr);
        in_valid  = iv;
        in_data   = id;
        stall_req = sr;
        flush     = fl;
        out_ready = orr;
        #1;
        last_rdy = in_ready;
        if (iv && in_ready) sb.push_back(id);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: pops expected words whenever the DUT delivers one.
    initial begin
        logic [WIDTH-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", {32'd0, out_data}, 64'hdead_beef_dead_beef);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_data", {32'd0, out_data}, {32'd0, e});
                    end
                end
                if (!out_valid) chk("bubble_zero", {32'd0, out_data}, 64'd0);
                if (flush) sb.delete();
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] hz_d[5];
        logic             hz_v[5];
        logic [CNT_W-1:0] snap;
        int               exp_sat;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; stall_req = 1'b0;
        flush = 1'b0; out_ready = 1'b1;
        #1;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_data", {32'd0, out_data}, 64'd0);
        chk("reset_stall_cnt", {60'd0, stall_cnt}, 64'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Streaming
        cyc(1'b1, 32'h11, 1'b0, 1'b0, 1'b1); chk("stream_rdy0", {63'd0, last_rdy}, 64'd1);
        chk("stream_lat0", {63'd0, out_valid}, 64'd0);
        cyc(1'b1, 32'h22, 1'b0, 1'b0, 1'b1); chk("stream_rdy1", {63'd0, last_rdy}, 64'd1);
        cyc(1'b1, 32'h33, 1'b0, 1'b0, 1'b1); chk("stream_rdy2", {63'd0, last_rdy}, 64'd1);
        chk("stream_lat2", {63'd0, out_valid}, 64'd0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("stream_e3", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h11});
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("stream_e4", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h22});
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("stream_e5", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h33});
        drain();

        // Hazard: two stall cycles with 0x22 in stage 0
        hz_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        hz_d = '{32'h11, 32'h0, 32'h0, 32'h22, 32'h33};
        cyc(1'b1, 32'h11, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h22, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h33, 1'b1, 1'b0, 1'b1); chk("hz_rdy0", {63'd0, last_rdy}, 64'd0);
        cyc(1'b1, 32'h33, 1'b1, 1'b0, 1'b1); chk("hz_rdy1", {63'd0, last_rdy}, 64'd0);
        chk("hz_out0", {31'd0, out_valid, out_data}, {31'd0, hz_v[0], hz_d[0]});
        cyc(1'b1, 32'h33, 1'b0, 1'b0, 1'b1); chk("hz_rdy2", {63'd0, last_rdy}, 64'd1);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("hz_out%0d", i), {31'd0, out_valid, out_data},
                {31'd0, hz_v[i], hz_d[i]});
            cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        end
        chk("hz_cnt", {60'd0, stall_cnt}, CNT_ON ? 64'd2 : 64'd0);
        drain();

        // Backpressure with stall_req asserted during freeze
        cyc(1'b1, 32'h11, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h22, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h33, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h44, 1'b0, 1'b0, 1'b1);
        snap = stall_cnt;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
            chk("frz_rdy", {63'd0, last_rdy}, 64'd0);
            chk("frz_hold", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h11});
        end
        chk("frz_cnt", {60'd0, stall_cnt}, CNT_ON ? 64'd2 : 64'd0);
        chk("frz_cnt_same", {60'd0, stall_cnt}, {60'd0, snap});
        cyc(1'b1, 32'h55, 1'b0, 1'b0, 1'b1); chk("frz_rel_rdy", {63'd0, last_rdy}, 64'd1);
        chk("frz_res0", {32'd0, out_data}, 64'h22);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1); chk("frz_res1", {32'd0, out_data}, 64'h33);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1); chk("frz_res2", {32'd0, out_data}, 64'h44);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1); chk("frz_res3", {32'd0, out_data}, 64'h55);
        drain();

        // Flush with three words in flight and 0x44 offered
        cyc(1'b1, 32'h11, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h22, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h33, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h44, 1'b0, 1'b1, 1'b1); chk("fl_rdy", {63'd0, last_rdy}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("fl_empty", {63'd0, out_valid}, 64'd0);
            cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        end
        cyc(1'b1, 32'h55, 1'b0, 1'b0, 1'b1); chk("fl_rdy55", {63'd0, last_rdy}, 64'd1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1); chk("fl_55_early", {63'd0, out_valid}, 64'd0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("fl_55", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h55});
        chk("fl_cnt_kept", {60'd0, stall_cnt}, CNT_ON ? 64'd2 : 64'd0);
        drain();

        // Asynchronous reset with a full pipe
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'hA0 + i, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_data", {32'd0, out_data}, 64'd0);
        chk("arst_cnt", {60'd0, stall_cnt}, 64'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
            chk("arst_empty", {63'd0, out_valid}, 64'd0);
        end

        // Counter saturation: 20 hazard cycles on a held word
        cyc(1'b1, 32'h66, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
            exp_sat = (i > 15) ? 15 : i;
            if (i == 5 || i == 15 || i == 20)
                chk($sformatf("sat_cnt%0d", i), {60'd0, stall_cnt},
                    CNT_ON ? 64'(exp_sat) : 64'd0);
        end
        drain();

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 25,
                $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75);
        end
        drain();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
